// File: rtl/pci_arbiter.sv
// pci_arbiter: central round-robin bus arbiter for a shared PCI segment.
// Hands the multiplexed bus to one of N initiators via active-low REQ#/GNT#
// pairs, inserts one turnaround cycle between owners, parks an idle bus on a
// fixed master and withdraws grants from masters that never start a cycle.
// Observes FRAME#/IRDY# only; drives no datapath signals.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   NREQ[N]      per-master request, active low
//   NFRAME       bus FRAME#, active low
//   NIRED        bus IRDY#, active low
//   NGNT[N]      per-master grant, active low, registered, at most one low
//   owner        index of the current or most recent grant holder
//   parked       current grant is a park grant with no request behind it
//   timeout_evt  one-cycle pulse when a grant is withdrawn by timeout
module pci_arbiter #(
    parameter int N       = 4,
    parameter int OW      = 2,
    parameter int TIMEOUT = 16,
    parameter int PARK    = 0,
    parameter int PARK_EN = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  NREQ,
    input  logic          NFRAME,
    input  logic          NIRED,
    output logic [N-1:0]  NGNT,
    output logic [OW-1:0] owner,
    output logic          parked,
    output logic          timeout_evt
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_BUSY  = 2'd2;
    localparam logic [1:0] ST_TURN  = 2'd3;

    logic [1:0]    state;
    logic [OW-1:0] last;
    logic [7:0]    cnt;

    logic          any_req;
    logic          other_req;
    logic          bus_idle;
    logic [OW-1:0] win;
    logic          found;

    // Round-robin search starting just after the last request-driven winner.
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int i = 1; i <= N; i++) begin
            int idx;
            idx = (int'(last) + i) % N;
            if (!found && !NREQ[idx]) begin
                win   = OW'(idx);
                found = 1'b1;
            end
        end
    end

    assign any_req   = |(~NREQ);
    // Any master other than the current owner wants the bus.
    assign other_req = |(~NREQ & ~(N'(1) << owner));
    assign bus_idle  = NFRAME && NIRED;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            NGNT        <= '1;
            owner       <= '0;
            parked      <= 1'b0;
            timeout_evt <= 1'b0;
            last        <= OW'(N - 1);
            cnt         <= '0;
        end else begin
            timeout_evt <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (!NFRAME) begin
                        // Foreign or stray cycle: track it, no grant.
                        state <= ST_BUSY;
                    end else if (any_req) begin
                        NGNT   <= ~(N'(1) << win);
                        owner  <= win;
                        last   <= win;
                        parked <= 1'b0;
                        state  <= ST_GRANT;
                    end else if (PARK_EN != 0) begin
                        // Park grants leave the round-robin pointer alone.
                        NGNT   <= ~(N'(1) << PARK);
                        owner  <= OW'(PARK);
                        parked <= 1'b1;
                        state  <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (!NFRAME) begin
                        // Cycle started: beats request drop and timeout.
                        state <= ST_BUSY;
                    end else if (!parked && NREQ[owner]) begin
                        NGNT  <= '1;
                        state <= ST_TURN;
                    end else if (parked && any_req) begin
                        NGNT   <= '1;
                        parked <= 1'b0;
                        state  <= ST_TURN;
                    end else if (!parked && cnt == 8'(TIMEOUT - 1)) begin
                        NGNT        <= '1;
                        timeout_evt <= 1'b1;
                        last        <= owner;
                        state       <= ST_TURN;
                    end else if (!parked) begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_BUSY: begin
                    if (bus_idle) begin
                        NGNT   <= '1;
                        parked <= 1'b0;
                        state  <= ST_TURN;
                    end else if (other_req) begin
                        // Early release: owner keeps the bus until it finishes.
                        NGNT   <= '1;
                        parked <= 1'b0;
                    end
                end
                default: begin
                    NGNT  <= '1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/pci_arbiter.md
# pci_arbiter

Central bus arbiter for the PCI segment served by `PCI_TARGET`. It shares the multiplexed `Address_Data`/`C_BE` bus among up to N initiators using active-low request/grant pairs. It uses fair round-robin priority, one turnaround cycle between bus owners, and a grant timeout for masters that never start a cycle. It watches `NFRAME` and `NIRED` to track bus ownership; it drives no datapath signals.

## Interface
- `N`, 4: number of initiators, 2..8.
- `OW`, 2: owner index width, `$clog2(N)`.
- `TIMEOUT`, 16: number of cycles a granted, idle bus may go without `NFRAME` low before the grant is withdrawn. Range 2..255.
- `PARK`, 0: index of the master that is parked on an idle bus.
- `PARK_EN`, 1: 1 enables bus parking.
- `clk` input 1: the single clock; all logic is on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `NREQ` input N: per-master request, active low.
- `NFRAME` input 1: bus FRAME#, active low.
- `NIRED` input 1: bus IRDY#, active low.
- `NGNT` output N: per-master grant, active low, registered. At most one bit is low.
- `owner` output OW: index of the current or most recent grant holder.
- `parked` output 1: the current grant is a park grant with no request behind it.
- `timeout_evt` output 1: one-cycle pulse when a grant is withdrawn by timeout.

## Operation
- Bus idle means `NFRAME`=1 and `NIRED`=1.
- States are IDLE, GRANT, BUSY and TURN.
- Round robin:
  - `last` register, reset value N-1.
  - Search order is `last`+1, `last`+2, … modulo N.
  - The first master with `NREQ` low wins.
  - `last` is updated to the winner only on request-driven grants, never on park grants.
- IDLE (all `NGNT` high):
  - If `NFRAME`=0 (foreign or stray cycle), go to BUSY; no grant is issued.
  - Else if any request, grant the winner W: `NGNT[W]`=0, `owner`=W, go to GRANT.
  - Else if `PARK_EN`, grant `PARK` with `parked`=1, go to GRANT.
- GRANT (one `NGNT` low; wait counter cleared on entry):
  - If `NFRAME`=0, go to BUSY; the grant stays asserted.
  - Else if not parked and `NREQ[owner]`=1, withdraw the grant and go to TURN.
  - Else if parked and any request is present, withdraw the grant and go to TURN.
  - Else if not parked and the wait counter reaches `TIMEOUT`-1:
    - withdraw the grant;
    - pulse `timeout_evt`;
    - set `last`=`owner`;
    - go to TURN.
  - Otherwise increment the counter. Parked grants never time out.
- BUSY:
  - Owner keeps `NGNT` low while no other master requests.
  - As soon as any other master's `NREQ` is low, all `NGNT` go high. This is the early release; the owner finishes its cycle.
  - When the bus is idle, go to TURN.
- TURN: all `NGNT` high for exactly one cycle, then IDLE.
- Same-edge events:
  - In GRANT, `NFRAME`=0 takes precedence over request drop and over timeout.
  - In IDLE, `NFRAME`=0 takes precedence over issuing a grant.
- The owner releasing `NREQ` during BUSY does not affect the transaction.
- `reset` at any cycle takes effect at the next edge, mid-transaction included:
  - all `NGNT`=1, `owner`=0, `parked`=0, `timeout_evt`=0, `last`=N-1;
  - state IDLE, wait counter 0.

## Timing
- All outputs are registered and change only on `clk` rising edges.
- Arbitration latency: a request sampled low in IDLE produces `NGNT` low after that same edge (1 cycle).
- Owner handover: the bus goes idle at edge k, TURN runs in cycle k..k+1, IDLE decides at edge k+2, and the new `NGNT` is low from k+2. Between owners there are always at least 2 cycles of all-high `NGNT`.
- Timeout: a grant issued at edge g with no `NFRAME` low is withdrawn at edge g+`TIMEOUT`. `timeout_evt` is high for the single cycle following that edge.
- The `NGNT` vector is never driven with two bits low in the same cycle.

## Test plan
- Reset: hold `reset`=1 for 2 cycles with `NREQ`=4'b0000 -> `NGNT`=4'b1111, `owner`=0, `timeout_evt`=0. The first grant after release goes to master 0.
- Single master: `NREQ`=4'b1011 (master 2) -> `NGNT`=4'b1011 one cycle later. Drive the write burst `NFRAME`/`NIRED` sequence; `NGNT` holds through BUSY and goes 4'b1111 for the TURN cycle after the bus idles.
- Round robin: all four request continuously and each runs a 2-data-phase cycle -> grant order 0,1,2,3,0. Early release is seen in every BUSY, and there are always ≥2 all-high cycles between grants.
- Timeout: master 1 requests and never asserts `NFRAME`, `TIMEOUT`=16 -> `NGNT[1]` low for exactly 16 cycles, then one `timeout_evt` pulse. If master 3 is also requesting, it is granted next.
- Parking: no requests, `PARK_EN`=1 -> `NGNT`=4'b1110 with `parked`=1 and no timeout after 100 cycles. Master 3 then requests -> TURN, then `NGNT`=4'b0111 with `parked`=0.
- Simultaneous/reset: in GRANT, `NFRAME` falls on the timeout edge -> BUSY with no `timeout_evt`. Asserting `reset` mid-BUSY -> all outputs at reset values at the next edge.
